// File: rtl/da_engine.sv
// da_engine: bit-serial distributed-arithmetic inner product (MSB first) over host-loaded
// coefficient-sum RAMs. Define DA_SAT_EN to clamp acc_out to the signed OUT_W range.
module da_engine #(
  parameter int unsigned NUM_TAPS = 16,
  parameter int unsigned LUT_IN   = 8,
  parameter int unsigned X_W      = 8,
  parameter int unsigned C_W      = 20,
  parameter int unsigned SIGNED_X = 1,
  parameter int unsigned OUT_W    = 39,
  localparam int unsigned NUM_ROM = NUM_TAPS / LUT_IN,
  localparam int unsigned AW      = $clog2(NUM_ROM) + LUT_IN
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clr,
  input  logic                      start,
  input  logic [NUM_TAPS*X_W-1:0]   x_in,
  input  logic                      cload,
  input  logic [AW-1:0]             caddr,
  input  logic [C_W-1:0]            cin,
  output logic                      busy,
  output logic [OUT_W-1:0]          acc_out,
  output logic                      valid_out,
  output logic                      sat,
  output logic                      coef_err
);

  localparam int unsigned RIW   = (NUM_ROM > 1) ? $clog2(NUM_ROM) : 1;
  localparam int unsigned BW    = (X_W > 1) ? $clog2(X_W) : 1;
  localparam int unsigned ACC_W = C_W + X_W + $clog2(NUM_ROM) + 1;
  localparam int unsigned DEPTH = 1 << LUT_IN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [C_W-1:0]   r_ram [NUM_ROM][DEPTH];
  logic [X_W-1:0]          r_x [NUM_TAPS];
  logic [BW-1:0]           r_bit, w_bit_nxt;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [OUT_W-1:0]        r_acc_out, w_acc_out_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_sat, w_sat_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_coef_err;
  logic                    w_load, w_shift;
  logic [RIW-1:0]          w_widx;
  logic [LUT_IN-1:0]       w_addr [NUM_ROM];
  logic signed [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0]        w_narrow;
  logic                    w_ovf;

  // Host write port; writes while a computation is running are rejected.
  assign w_widx = RIW'(caddr >> LUT_IN);

  always_ff @(posedge clk) begin
    if (cload && !r_busy) r_ram[w_widx][caddr[LUT_IN-1:0]] <= cin;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_coef_err <= 1'b0;
    else         r_coef_err <= cload && r_busy;
  end

  // Current bit slice of each tap group forms that group's RAM address.
  always_comb begin
    w_addr = '{default: '0};
    for (int r = 0; r < NUM_ROM; r++) begin
      for (int j = 0; j < LUT_IN; j++) begin
        w_addr[r][j] = r_x[r*LUT_IN + j][X_W-1];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int r = 0; r < NUM_ROM; r++) begin
      w_sum = w_sum + ACC_W'(r_ram[r][w_addr[r]]);
    end
  end

  generate
    if (OUT_W >= ACC_W) begin : g_ext
      assign w_narrow = OUT_W'(r_acc);
      assign w_ovf    = 1'b0;
    end else begin : g_narrow
`ifdef DA_SAT_EN
      logic [ACC_W-OUT_W:0] w_top;
      assign w_top    = r_acc[ACC_W-1:OUT_W-1];
      assign w_ovf    = !((&w_top) || !(|w_top));
      assign w_narrow = !w_ovf          ? r_acc[OUT_W-1:0] :
                        r_acc[ACC_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                          {1'b0, {(OUT_W-1){1'b1}}};
`else
      assign w_ovf    = 1'b0;
      assign w_narrow = r_acc[OUT_W-1:0];
`endif
    end
  endgenerate

  // Next-state and output logic; clr overrides everything else.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_nxt     = r_bit;
    w_acc_nxt     = r_acc;
    w_acc_out_nxt = r_acc_out;
    w_valid_nxt   = 1'b0;
    w_sat_nxt     = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_bit_nxt   = BW'(X_W - 1);
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_shift = 1'b1;
        if (r_bit == BW'(X_W - 1)) w_acc_nxt = (SIGNED_X != 0) ? -w_sum : w_sum;
        else                       w_acc_nxt = (r_acc <<< 1) + w_sum;
        w_bit_nxt = r_bit - BW'(1);
        if (r_bit == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_valid_nxt   = 1'b1;
        w_sat_nxt     = w_ovf;
        w_acc_out_nxt = w_narrow;
        if (start) begin
          w_load      = 1'b1;
          w_bit_nxt   = BW'(X_W - 1);
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clr) begin
      w_state_nxt   = S_IDLE;
      w_acc_nxt     = '0;
      w_acc_out_nxt = '0;
      w_valid_nxt   = 1'b0;
      w_sat_nxt     = 1'b0;
      w_load        = 1'b0;
      w_shift       = 1'b0;
    end
    w_busy_nxt = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_bit     <= '0;
      r_acc     <= '0;
      r_acc_out <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit     <= w_bit_nxt;
      r_acc     <= w_acc_nxt;
      r_acc_out <= w_acc_out_nxt;
      r_valid   <= w_valid_nxt;
      r_sat     <= w_sat_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Sample shift registers: MSB always presents the bit being processed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_TAPS; k++) r_x[k] <= '0;
    end else if (w_load) begin
      for (int k = 0; k < NUM_TAPS; k++) r_x[k] <= x_in[k*X_W +: X_W];
    end else if (w_shift) begin
      for (int k = 0; k < NUM_TAPS; k++) r_x[k] <= r_x[k] << 1;
    end
  end

  assign busy      = r_busy;
  assign acc_out   = r_acc_out;
  assign valid_out = r_valid;
  assign sat       = r_sat;
  assign coef_err  = r_coef_err;

endmodule

// File: tb/tb_da_engine.sv
// Scoreboard bench for da_engine: signed, unsigned and 24-bit-output instances share stimulus;
// a monitor pops expected results whenever valid_out is seen.
module tb_da_engine;

  localparam int unsigned NT = 16;
  localparam int unsigned XW = 8;
  localparam int unsigned CW = 20;
  localparam int unsigned AW = 9;

  logic clk = 1'b0;
  logic resetn, clr, start, cload;
  logic [NT*XW-1:0] x_in;
  logic [AW-1:0]    caddr;
  logic [CW-1:0]    cin;

  logic        busy_s, valid_s, sat_s, cerr_s;
  logic [38:0] acc_s;
  logic        busy_u, valid_u, sat_u, cerr_u;
  logic [38:0] acc_u;
  logic        busy_w, valid_w, sat_w, cerr_w;
  logic [23:0] acc_w;

  da_engine u_dut_s (
    .clk(clk), .resetn(resetn), .clr(clr), .start(start), .x_in(x_in),
    .cload(cload), .caddr(caddr), .cin(cin), .busy(busy_s), .acc_out(acc_s),
    .valid_out(valid_s), .sat(sat_s), .coef_err(cerr_s)
  );

  da_engine #(.SIGNED_X(0)) u_dut_u (
    .clk(clk), .resetn(resetn), .clr(clr), .start(start), .x_in(x_in),
    .cload(cload), .caddr(caddr), .cin(cin), .busy(busy_u), .acc_out(acc_u),
    .valid_out(valid_u), .sat(sat_u), .coef_err(cerr_u)
  );

  da_engine #(.OUT_W(24)) u_dut_w (
    .clk(clk), .resetn(resetn), .clr(clr), .start(start), .x_in(x_in),
    .cload(cload), .caddr(caddr), .cin(cin), .busy(busy_w), .acc_out(acc_w),
    .valid_out(valid_w), .sat(sat_w), .coef_err(cerr_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [38:0] s;
    logic [38:0] u;
    logic [23:0] w;
    logic        wsat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: every valid_out must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && (valid_s || valid_u || valid_w)) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'({valid_s, valid_u, valid_w}), 64'd0);
      end else begin
        m_e = q.pop_front();
        chk("valid_all", 64'({valid_s, valid_u, valid_w}), 64'b111);
        chk("acc_s",   64'(acc_s), 64'(m_e.s));
        chk("acc_u",   64'(acc_u), 64'(m_e.u));
        chk("acc_w",   64'(acc_w), 64'(m_e.w));
        chk("sat_su",  64'({sat_s, sat_u}), 64'd0);
        chk("sat_w",   64'(sat_w), 64'(m_e.wsat));
        chk("latency", 64'(cyc), 64'(m_e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int r, input int a, input int v);
    cload = 1'b1;
    caddr = AW'((r << 8) | a);
    cin   = CW'(v);
    tick();
    cload = 1'b0;
  endtask

  // mode 0: RAM0[a]=a, RAM1=0; mode 1: RAM0[a]=a, RAM1[a]=1000a; mode 2: nonzero entries 2^19-1
  task automatic load_ram(input int mode);
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 256; a++) begin
        int v;
        case (mode)
          0:       v = (r == 0) ? a : 0;
          1:       v = (r == 0) ? a : 1000 * a;
          default: v = (a == 0) ? 0 : 524287;
        endcase
        write_coef(r, a, v);
      end
    end
  endtask

  function automatic logic [NT*XW-1:0] mkx(input int tap, input int val);
    logic [NT*XW-1:0] x;
    x = '0;
    x[tap*XW +: XW] = XW'(val);
    return x;
  endfunction

  function automatic exp_t mke(input longint s, input longint u, input longint w, input logic ws);
    exp_t e;
    e.s = 39'(s);
    e.u = 39'(u);
    e.w = 24'(w);
    e.wsat = ws;
    e.cyc = 0;
    return e;
  endfunction

  task automatic run(input logic [NT*XW-1:0] x, input exp_t e_in);
    exp_t e;
    e = e_in;
    x_in  = x;
    start = 1'b1;
    e.cyc = cyc + 10;
    q.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 64'(q.size()), 64'd0);
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s"}, 64'({busy_s, valid_s, sat_s, cerr_s, acc_s}), 64'd0);
    chk({tag, "_u"}, 64'({busy_u, valid_u, sat_u, cerr_u, acc_u}), 64'd0);
    chk({tag, "_w"}, 64'({busy_w, valid_w, sat_w, cerr_w, acc_w}), 64'd0);
  endtask

  logic [NT*XW-1:0] x33;
  exp_t e_tmp;

  initial begin
    resetn = 1'b1;
    clr    = 1'b0;
    start  = 1'b0;
    cload  = 1'b0;
    caddr  = '0;
    cin    = '0;
    x_in   = '0;
    #3 resetn = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    resetn = 1'b1;
    tick();

    load_ram(0);
    run(mkx(0, 3), mke(3, 3, 3, 1'b0));
    drain("drain_x0_3");
    run(mkx(1, 5), mke(10, 10, 10, 1'b0));
    drain("drain_x1_5");
    run(mkx(0, 8'hFF), mke(-1, 255, -1, 1'b0));
    drain("drain_x0_ff");

    // Back-to-back: start held through DONE gives a second result 9 cycles later.
    load_ram(1);
    e_tmp = mke(-128000, 128000, -128000, 1'b0);
    x_in  = mkx(8, 8'h80);
    start = 1'b1;
    e_tmp.cyc = cyc + 10;
    q.push_back(e_tmp);
    e_tmp.cyc = cyc + 19;
    q.push_back(e_tmp);
    repeat (10) tick();
    start = 1'b0;
    drain("drain_b2b");

    // Rejected write and ignored start while busy.
    x33 = mkx(0, 3) | mkx(1, 3);
    run(x33, mke(9, 9, 9, 1'b0));
    repeat (2) tick();
    chk("busy_run", 64'({busy_s, busy_u, busy_w}), 64'b111);
    cload = 1'b1;
    caddr = AW'(3);
    cin   = CW'(999);
    start = 1'b1;
    x_in  = mkx(0, 100);
    tick();
    cload = 1'b0;
    start = 1'b0;
    chk("coef_err_pulse", 64'({cerr_s, cerr_u, cerr_w}), 64'b111);
    tick();
    chk("coef_err_clear", 64'({cerr_s, cerr_u, cerr_w}), 64'd0);
    drain("drain_busy_run");
    run(x33, mke(9, 9, 9, 1'b0));
    drain("drain_rerun");

    // clr mid-run: no result, engine idle, next run intact.
    x_in  = mkx(0, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("busy_after_clr", 64'({busy_s, busy_u, busy_w}), 64'd0);
    repeat (12) tick();
    run(x33, mke(9, 9, 9, 1'b0));
    drain("drain_after_clr");

    // resetn mid-run: everything zero immediately, coefficients retained.
    x_in  = mkx(1, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    chk_zero("midreset");
    tick();
    resetn = 1'b1;
    repeat (12) tick();
    run(x33, mke(9, 9, 9, 1'b0));
    drain("drain_after_reset");

    // Large result: overflows the 24-bit output.
    load_ram(2);
    x_in = '0;
    for (int k = 0; k < 16; k++) x_in[k*XW +: XW] = 8'h7F;
`ifdef DA_SAT_EN
    run(x_in, mke(133168898, 133168898, 8388607, 1'b1));
`else
    run(x_in, mke(133168898, 133168898, 24'hEFFF02, 1'b0));
`endif
    drain("drain_sat");

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
